// File: rtl/alu_cdb_unit.sv
// RV32I integer execution stage feeding the common data bus through a small in-order result queue.
// A single execute register feeds the queue; ex_ready_o back-pressures dispatch so the queue never overflows.
module alu_cdb_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             ex_valid_i,
    input  logic [OP_W-1:0]  ex_op_i,
    input  logic [XLEN-1:0]  ex_v1_i,
    input  logic [XLEN-1:0]  ex_v2_i,
    input  logic [TAG_W-1:0] ex_tag_i,
    output logic             ex_ready_o,
    output logic             cdb_req_o,
    input  logic             cdb_gnt_i,
    output logic             cdb_valid_o,
    output logic [TAG_W-1:0] cdb_tag_o,
    output logic [XLEN-1:0]  cdb_value_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SH_W  = $clog2(XLEN);

    localparam logic [OP_W-1:0] ALU_OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_OP_SLL  = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_OP_SRL  = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_OP_SRA  = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_OP_SLT  = OP_W'(8);
    localparam logic [OP_W-1:0] ALU_OP_SLTU = OP_W'(9);

    logic             e_valid;
    logic [OP_W-1:0]  e_op;
    logic [XLEN-1:0]  e_v1;
    logic [XLEN-1:0]  e_v2;
    logic [TAG_W-1:0] e_tag;
    logic [XLEN-1:0]  e_result;
    logic [SH_W-1:0]  shamt;

    logic [TAG_W-1:0] q_tag [DEPTH];
    logic [XLEN-1:0]  q_val [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic accept;
    logic push;
    logic pop;

    // Readiness counts the op sitting in E so a stalled queue can never be overrun.
    assign ex_ready_o  = (count + CNT_W'(e_valid)) <= CNT_W'(DEPTH - 1);
    assign accept      = ex_valid_i & ex_ready_o;
    assign push        = e_valid;
    assign cdb_req_o   = (count != '0);
    assign cdb_valid_o = cdb_req_o & cdb_gnt_i;
    assign pop         = cdb_valid_o;
    assign cdb_tag_o   = cdb_req_o ? q_tag[rptr] : '0;
    assign cdb_value_o = cdb_req_o ? q_val[rptr] : '0;
    assign shamt       = e_v2[SH_W-1:0];

    // ALU datapath evaluated from the execute register.
    always_comb begin
        e_result = '0;
        case (e_op)
            ALU_OP_ADD:  e_result = e_v1 + e_v2;
            ALU_OP_SUB:  e_result = e_v1 - e_v2;
            ALU_OP_AND:  e_result = e_v1 & e_v2;
            ALU_OP_OR:   e_result = e_v1 | e_v2;
            ALU_OP_XOR:  e_result = e_v1 ^ e_v2;
            ALU_OP_SLL:  e_result = e_v1 << shamt;
            ALU_OP_SRL:  e_result = e_v1 >> shamt;
            ALU_OP_SRA:  e_result = XLEN'($signed(e_v1) >>> shamt);
            ALU_OP_SLT:  e_result = XLEN'($signed(e_v1) < $signed(e_v2));
            ALU_OP_SLTU: e_result = XLEN'(e_v1 < e_v2);
            default:     e_result = '0;
        endcase
    end

    // Control state: flush has priority over accept, push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
        end else if (flush_i) begin
            e_valid <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
        end else begin
            e_valid <= accept;
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload registers carry no reset; they are qualified by e_valid and count.
    always_ff @(posedge clk) begin
        if (accept) begin
            e_op  <= ex_op_i;
            e_v1  <= ex_v1_i;
            e_v2  <= ex_v2_i;
            e_tag <= ex_tag_i;
        end
        if (push) begin
            q_tag[wptr] <= e_tag;
            q_val[wptr] <= e_result;
        end
    end

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Randomized and directed bench for alu_cdb_unit against an in-order transaction model.
module tb_alu_cdb_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                           OP_XOR = 5'd4, OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                           OP_SLT = 5'd8, OP_SLTU = 5'd9, OP_BAD = 5'd17;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [4:0]  ex_op_i = '0;
    logic [31:0] ex_v1_i = '0;
    logic [31:0] ex_v2_i = '0;
    logic [3:0]  ex_tag_i = '0;
    logic        ex_ready_o;
    logic        cdb_req_o;
    logic        cdb_gnt_i = 1'b0;
    logic        cdb_valid_o;
    logic [3:0]  cdb_tag_o;
    logic [31:0] cdb_value_o;

    int checks = 0;
    int failures = 0;

    ent_t pend[$];  // accepted, not yet visible on the bus
    ent_t vis[$];   // visible, waiting for grant, oldest first
    ent_t iss[$];   // every accepted op in order
    ent_t got[$];   // every DUT broadcast in order

    alu_cdb_unit #(.XLEN(32), .TAG_W(4), .OP_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i), .ex_v1_i(ex_v1_i),
        .ex_v2_i(ex_v2_i), .ex_tag_i(ex_tag_i), .ex_ready_o(ex_ready_o),
        .cdb_req_o(cdb_req_o), .cdb_gnt_i(cdb_gnt_i), .cdb_valid_o(cdb_valid_o),
        .cdb_tag_o(cdb_tag_o), .cdb_value_o(cdb_value_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned s;
        s = int'(b[4:0]);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << s;
            OP_SRL:  return a >> s;
            OP_SRA:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Every accepted op not yet broadcast occupies one slot of DEPTH.
    function automatic logic m_ready();
        return (pend.size() + vis.size()) < DEPTH;
    endfunction

    function automatic logic [38:0] exp_vec();
        logic req;
        ent_t h;
        req = (vis.size() != 0);
        h = '0;
        if (req) h = vis[0];
        return {m_ready(), req, req & cdb_gnt_i, h.tag, h.val};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {ex_ready_o, cdb_req_o, cdb_valid_o, cdb_tag_o, cdb_value_o};
    endfunction

    task automatic model_edge();
        logic acc;
        logic pop;
        ent_t n;
        acc = ex_valid_i && m_ready();
        pop = (vis.size() != 0) && cdb_gnt_i;
        if (!rst || flush_i) begin
            pend.delete();
            vis.delete();
        end else begin
            if (pop) void'(vis.pop_front());
            if (pend.size() != 0) vis.push_back(pend.pop_front());
            if (acc) begin
                n.tag = ex_tag_i;
                n.val = alu_ref(ex_op_i, ex_v1_i, ex_v2_i);
                pend.push_back(n);
                iss.push_back(n);
            end
        end
    endtask

    // One clock: sample at negedge, advance model at posedge, return just after the edge.
    task automatic tick(output logic [38:0] o, output logic [38:0] e);
        @(negedge clk);
        o = dut_vec();
        e = exp_vec();
        if (cdb_valid_o) got.push_back({cdb_tag_o, cdb_value_o});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic v, logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] t);
        ex_valid_i = v;
        ex_op_i = op;
        ex_v1_i = a;
        ex_v2_i = b;
        ex_tag_i = t;
    endtask

    task automatic drive_rand();
        drive(1'b1, 5'($urandom_range(0, 15)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic test_reset();
        logic [38:0] o, e;
        rst = 1'b0;
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tick(o, e);
            checks++;
            if (o !== {1'b1, 38'h0}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, {1'b1, 38'h0});
            end
        end
        rst = 1'b1;
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick(o, e);
            checks++;
            if (o !== {1'b1, 38'h0}) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, o, {1'b1, 38'h0});
            end
        end
    endtask

    task automatic test_single_add();
        logic [38:0] o, e;
        int vcyc;
        vcyc = -1;
        got.delete();
        cdb_gnt_i = 1'b1;
        drive(1'b1, OP_ADD, 32'd256, 32'd16, 4'd10);
        tick(o, e);
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        for (int i = 1; i <= 5; i++) begin
            tick(o, e);
            if (o[36] && vcyc < 0) vcyc = i;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_add cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (got.size() != 1 || got[0] !== {4'd10, 32'd272} || vcyc != 2) begin
            failures++;
            $display("FAIL single_add_result n=%0d first=%h cyc=%0d exp_n=1 exp=%h exp_cyc=2",
                     got.size(), (got.size() != 0) ? got[0] : ent_t'(0), vcyc, {4'd10, 32'd272});
        end
    endtask

    task automatic test_arith_edges();
        logic [38:0] o, e;
        logic [4:0]  ops [9] = '{OP_SUB, OP_SRA, OP_SRL, OP_SLL, OP_SLT, OP_SLTU, OP_BAD, OP_XOR, OP_OR};
        logic [31:0] a   [9] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd3, 32'hF0F0_0000, 32'h0000_1200};
        logic [31:0] b   [9] = '{32'd7, 32'd4, 32'd4, 32'd33, 32'd1, 32'd1, 32'd4,
                                 32'h0FF0_00FF, 32'h0000_0034};
        logic [31:0] r   [9] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0800_0000, 32'd2, 32'd1,
                                 32'd0, 32'd0, 32'hFF00_00FF, 32'h0000_1234};
        got.delete();
        cdb_gnt_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i < 9) drive(1'b1, ops[i], a[i], b[i], 4'(i + 1));
            else drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
            tick(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL arith cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== {4'(i + 1), r[i]}) begin
                failures++;
                $display("FAIL arith_order idx=%0d got=%h exp=%h", i,
                         (i < got.size()) ? got[i] : ent_t'(0), {4'(i + 1), r[i]});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [38:0] o, e;
        int cur, pcyc, rcyc;
        cur = 1;
        pcyc = -1;
        rcyc = -1;
        got.delete();
        cdb_gnt_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(cur <= 5, OP_ADD, 32'(cur * 100), 32'(cur), 4'(cur));
            tick(o, e);
            if (e[38] && cur <= 5) cur++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (ex_ready_o !== 1'b0 || cur != 5) begin
            failures++;
            $display("FAIL bp_full ready=%b next_tag=%0d exp_ready=0 exp_next_tag=5", ex_ready_o, cur);
        end
        cdb_gnt_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(cur <= 5, OP_ADD, 32'(cur * 100), 32'(cur), 4'(cur));
            tick(o, e);
            if (e[38] && cur <= 5) cur++;
            if (o[36] && pcyc < 0) pcyc = i;
            if (o[38] && rcyc < 0) rcyc = i;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bp_drain cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (pcyc != 0 || rcyc != 1) begin
            failures++;
            $display("FAIL bp_ready_rise pop_cyc=%0d ready_cyc=%0d exp=0,1", pcyc, rcyc);
        end
        for (int t = 1; t <= 5; t++) begin
            checks++;
            if (t > got.size() || got[t-1] !== {4'(t), 32'(t * 101)}) begin
                failures++;
                $display("FAIL bp_order idx=%0d got=%h exp=%h", t,
                         (t <= got.size()) ? got[t-1] : ent_t'(0), {4'(t), 32'(t * 101)});
            end
        end
    endtask

    task automatic test_full_pushpop();
        logic [38:0] o, e;
        int nacc;
        got.delete();
        iss.delete();
        cdb_gnt_i = 1'b0;
        for (int i = 0; i < 10 && m_ready(); i++) begin
            drive_rand();
            tick(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL full_fill cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        cdb_gnt_i = 1'b1;
        nacc = 0;
        for (int i = 0; i < 40 && nacc < 10; i++) begin
            drive_rand();
            tick(o, e);
            if (e[38]) nacc++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL full_stream cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        // Mixed random valid, grant and ops.
        for (int i = 0; i < 80; i++) begin
            drive_rand();
            ex_valid_i = 1'($urandom_range(0, 1));
            cdb_gnt_i = ($urandom_range(0, 3) != 0);
            tick(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rand_mix cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        ex_valid_i = 1'b0;
        cdb_gnt_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (nacc < 10 || got.size() != iss.size()) begin
            failures++;
            $display("FAIL full_count accepted=%0d bcast=%0d exp_bcast=%0d", nacc, got.size(), iss.size());
        end
        for (int i = 0; i < iss.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== iss[i]) begin
                failures++;
                $display("FAIL full_order idx=%0d got=%h exp=%h", i, got[i], iss[i]);
            end
        end
    endtask

    task automatic test_flush_and_reset();
        logic [38:0] o, e;
        cdb_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_ADD, 32'(i), 32'd1000, 4'(i + 1));
            tick(o, e);
        end
        flush_i = 1'b1;
        cdb_gnt_i = 1'b1;
        drive(1'b1, OP_SUB, 32'd9, 32'd1, 4'd15);
        tick(o, e);
        checks++;
        if (o !== e || o[36] !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle got=%h exp=%h", o, e);
        end
        flush_i = 1'b0;
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        checks++;
        if (dut_vec() !== {1'b1, 38'h0}) begin
            failures++;
            $display("FAIL flush_after got=%h exp=%h", dut_vec(), {1'b1, 38'h0});
        end
        @(posedge clk);
        model_edge();
        #1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            if (i < 2) drive(1'b1, OP_XOR, 32'h55, 32'(i), 4'(12 + i));
            else drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
            tick(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL post_flush cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (got.size() != 2 || got[0] !== {4'd12, 32'h55} || got[1] !== {4'd13, 32'h54}) begin
            failures++;
            $display("FAIL post_flush_tags n=%0d exp_n=2", got.size());
        end
        cdb_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_OR, 32'(i), 32'h100, 4'(i + 5));
            tick(o, e);
        end
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== {1'b1, 38'h0}) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(), {1'b1, 38'h0});
        end
        pend.delete();
        vis.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cdb_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(o, e);
            checks++;
            if (o !== {1'b1, 38'h0}) begin
                failures++;
                $display("FAIL reset_no_partial cyc=%0d got=%h exp=%h", i, o, {1'b1, 38'h0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_arith_edges();
        test_backpressure();
        test_full_pushpop();
        test_flush_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
